// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: pipelined two's-complement adder/subtractor.
// A WIDTH-bit add is split into SEGMENTS carry-linked segments. Each pipeline
// stage resolves one segment and passes the carry forward. All stages advance
// together under a single valid/ready handshake, so backpressure is complete.
// Optional feature: define SEG_PIPE_ADDER_SAT_EN to saturate the sum on
// signed overflow. This adds no latency.
module seg_pipe_adder #(
  parameter int WIDTH    = 16,
  parameter int SEGMENTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SEG_W = WIDTH / SEGMENTS;

  if (WIDTH % SEGMENTS != 0) begin : g_bad_cfg
    $error("seg_pipe_adder: WIDTH must be a multiple of SEGMENTS");
  end

  // The whole pipeline moves as one unit, so a single enable serves every stage.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // These are the next-state values for the output register, produced by the last stage.
  logic [WIDTH-1:0] sum_n;
  logic             carry_n;
  logic             ovf_n;
  logic             valid_n;

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
    // REM is the count of operand bits that are still unresolved when they enter stage k.
    localparam int REM = WIDTH - k * SEG_W;

    logic [REM-1:0]           a_i;
    logic [REM-1:0]           b_i;
    logic                     c_i;
    logic                     v_i;
    logic [SEG_W:0]           seg_add;
    logic [(k+1)*SEG_W-1:0]   r_n;

    if (k == 0) begin : g_src
      // Subtraction is computed as A + ~B + 1. In that case carry_in is ignored.
      assign a_i = a;
      assign b_i = sub ? ~b : b;
      assign c_i = sub | carry_in;
      assign v_i = in_valid;
      assign r_n = seg_add[SEG_W-1:0];
    end else begin : g_src
      assign a_i = g_stage[k-1].g_reg.a_q;
      assign b_i = g_stage[k-1].g_reg.b_q;
      assign c_i = g_stage[k-1].g_reg.c_q;
      assign v_i = g_stage[k-1].g_reg.v_q;
      assign r_n = {seg_add[SEG_W-1:0], g_stage[k-1].g_reg.r_q};
    end

    // This is the segment add. The extra top bit is the carry into the next segment.
    assign seg_add = {1'b0, a_i[SEG_W-1:0]} + {1'b0, b_i[SEG_W-1:0]}
                   + {{SEG_W{1'b0}}, c_i};

    if (k < SEGMENTS - 1) begin : g_reg
      logic [REM-SEG_W-1:0]   a_q;
      logic [REM-SEG_W-1:0]   b_q;
      logic [(k+1)*SEG_W-1:0] r_q;
      logic                   c_q;
      logic                   v_q;

      // The stage valid bit is the only state here that must be cleared by reset.
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= v_i;
        end
      end

      // This is the stage data: resolved low bits, skewed high operand bits, and the carry.
      // NOTE: data flops carry no reset; a bubble's contents are masked by its valid bit.
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_i[REM-1:SEG_W];
          b_q <= b_i[REM-1:SEG_W];
          r_q <= r_n;
          c_q <= seg_add[SEG_W];
        end
      end
    end else begin : g_last
      logic             msb_cin;
      logic             ovf;
      logic [WIDTH-1:0] wrapped;

      // The carry into the MSB is recovered from the MSB sum bit and the MSB operand bits.
      assign msb_cin = a_i[SEG_W-1] ^ b_i[SEG_W-1] ^ seg_add[SEG_W-1];
      assign ovf     = msb_cin ^ seg_add[SEG_W];
      assign wrapped = r_n;

`ifdef SEG_PIPE_ADDER_SAT_EN
      // When overflow occurs, A and B' share a sign, so the sign of A picks the rail.
      assign sum_n = !ovf ? wrapped
                   : (a_i[SEG_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}});
`else
      assign sum_n = wrapped;
`endif
      assign carry_n = seg_add[SEG_W];
      assign ovf_n   = ovf;
      assign valid_n = v_i;
    end
  end

  // The output register is the last pipeline stage, and all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (advance) begin
      out_valid <= valid_n;
      sum       <= sum_n;
      carry_out <= carry_n;
      overflow  <= ovf_n;
    end
  end

endmodule

// File: tb/tb_seg_pipe_adder.sv
// tb_seg_pipe_adder: self-checking bench for seg_pipe_adder (WIDTH=16, SEGMENTS=4).
// It runs directed vectors from a table, a stall sequence, a mid-flight reset, and
// randomized streaming against a queue-based arithmetic reference model.
module tb_seg_pipe_adder;

  localparam int WIDTH    = 16;
  localparam int SEGMENTS = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  seg_pipe_adder #(.WIDTH(WIDTH), .SEGMENTS(SEGMENTS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  logic [17:0] exp_q[$];   // {overflow, carry_out, sum}
  logic [15:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The reference model works on the full word with plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin, input logic s);
    int unsigned ua, ub, total;
    logic [15:0] res;
    logic        cout, ovf;
    logic        sa, sb;
    ua    = int'(x);
    ub    = s ? (32'hFFFF - int'(y)) : int'(y);
    total = ua + ub + (s ? 1 : int'(cin));
    res   = total[15:0];
    cout  = (total > 32'hFFFF);
    sa    = (ua >= 32'h8000);
    sb    = (ub >= 32'h8000);
    ovf   = (sa == sb) && (res[15] != sa);
`ifdef SEG_PIPE_ADDER_SAT_EN
    if (ovf) res = sa ? 16'h8000 : 16'h7FFF;
`endif
    return {ovf, cout, res};
  endfunction

  // Per-cycle scoreboard step. It is called at the falling edge, after the inputs settle.
  task automatic eval_cycle();
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("stream_result", 32'({overflow, carry_out, sum}), 32'(exp_q[0]));
        if (out_ready) begin
          got_q.push_back(sum);
          void'(exp_q.pop_front());
        end
      end
    end
    check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
    if (in_valid && in_ready) exp_q.push_back(model(a, b, carry_in, sub));
  endtask

  // One isolated operation. It checks the exact latency and then the result.
  task automatic run_single(input string name, input logic [15:0] xa, input logic [15:0] xb,
                            input logic cin, input logic s, input logic [15:0] es,
                            input logic ec, input logic eo);
    @(posedge clk); #1;
    in_valid = 1'b1; a = xa; b = xb; carry_in = cin; sub = s; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (SEGMENTS - 2) @(posedge clk);
    #1;
    check({name, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_sum"},   32'(sum),       32'(es));
    check({name, "_cout"},  32'(carry_out), 32'(ec));
    check({name, "_ovf"},   32'(overflow),  32'(eo));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];

  initial begin
    int idx, stall_left;
    bit seen, xfer;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef SEG_PIPE_ADDER_SAT_EN
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h0003, 16'h0004, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum",       32'(sum),       32'd0);
    check("reset_cout",      32'(carry_out), 32'd0);
    check("reset_ovf",       32'(overflow),  32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Run the directed table.
    for (int i = 0; i < 9; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                 vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Six back-to-back ops, then a 3-cycle stall starting when the first result appears.
    exp_q.delete(); got_q.delete();
    idx = 1; seen = 0; stall_left = 0;
    for (int cyc = 0; cyc < 40 && got_q.size() < 6; cyc++) begin
      @(posedge clk); #1;
      if (out_valid && !seen) begin
        seen = 1; stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid  = (idx <= 6);
      a = 16'(idx); b = 16'(idx); carry_in = 1'b0; sub = 1'b0;
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_hold_sum", 32'(sum),      32'h0002);
        stall_left--;
      end
      xfer = in_valid && in_ready;
      eval_cycle();
      if (xfer) idx++;
    end
    check("stall_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      check($sformatf("stall_order%0d", i), 32'(got_q[i]), 32'(2 * (i + 1)));
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Fill the pipe, then reset while results are in flight.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 16'(16'h0010 * (i + 1)); b = 16'h0001; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("prereset_valid", 32'(out_valid), 32'd1);
    check("prereset_sum",   32'(sum),       32'h0011);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",       32'(sum),       32'd0);
    check("midrst_cout",      32'(carry_out), 32'd0);
    check("midrst_ovf",       32'(overflow),  32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    run_single("post_reset", 16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Randomized streaming with random backpressure.
    exp_q.delete(); got_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       a = 16'h7FFF - 16'($urandom_range(0, 3));
        1:       a = 16'h8000 + 16'($urandom_range(0, 3));
        default: a = 16'($urandom);
      endcase
      b        = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      carry_in = 1'($urandom);
      sub      = 1'($urandom);
      @(negedge clk);
      eval_cycle();
    end
    for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      eval_cycle();
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; next generation of the team's 1-bit full-adder block.
- Splits a WIDTH-bit operation into SEGMENTS carry-linked segments, one segment resolved per pipeline stage; carry ripples stage to stage.
- Valid/ready handshake on input and output with full backpressure.
- Used as the shared arithmetic unit feeding datapath accumulators.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SEGMENTS, 4, number of pipeline stages; WIDTH % SEGMENTS == 0 is required (elaboration error otherwise); SEG_W = WIDTH/SEGMENTS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  carry into bit 0 (ignored when sub=1)
- sub  input  1  0: A+B+carry_in; 1: A-B (A + ~B + 1)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- carry_out  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, release synchronous to clk):
  - All stage valid bits, out_valid, sum, carry_out and overflow = 0.
  - in_ready = 1 after reset.
- Global advance = !out_valid || out_ready; in_ready = advance (combinational).
  - Transfer in: in_valid && in_ready at a rising edge.
  - Transfer out: out_valid && out_ready.
- Stage k (0..SEGMENTS-1):
  - Adds segment k of A and B' (B' = sub ? ~b : b) with the carry from stage k-1.
  - Stage 0 uses carry_in, or 1 when sub=1.
  - Registers resolved low bits, the skewed unresolved high operand bits, the carry, and a valid bit.
- All stages shift together only when advance=1; when advance=0 every stage holds, including bubbles. There is no bubble collapse.
- Latency: a transfer in cycle N yields out_valid in cycle N+SEGMENTS when out_ready stays high.
- Throughput: one operation per cycle.
- Ordering: strictly FIFO; no drop, no duplication.
- Arithmetic:
  - Full WIDTH-bit modulo result.
  - carry_out is the final-stage carry.
  - overflow is computed in the last stage from the MSB carry-in and carry-out.
- Outputs are driven directly from the last stage registers; no combinational path from a/b to sum.
- Output hold: while out_valid=1 and out_ready=0, sum, carry_out and overflow are stable.
- Bubbles: stages with valid=0 may carry don't-care data, but out_valid must be 0 for them.
- Reset mid-operation: all in-flight results are discarded and the outputs return to their reset values immediately.
- Simultaneous in/out transfer in the same cycle is legal and the normal steady state.
- SEGMENTS=1 degenerates to a single registered adder with latency 1.

Optional Feature:
- Macro SEG_PIPE_ADDER_SAT_EN.
- Defined:
  - On signed overflow, sum saturates: 0x7F..F if the operands are non-negative, 0x80..0 if negative. For sub, the sign of B' is used.
  - overflow still reports 1; carry_out is unchanged.
  - Saturation is applied in the last stage with no added latency.
- Undefined: sum is the wrapped modulo result; no saturation logic is instantiated.

Test Plan (WIDTH=16, SEGMENTS=4, out_ready=1 unless stated):
- a=0x00FF, b=0x0001, cin=0, sub=0 -> cycle N+4: sum=0x0100, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry_out=1, overflow=0 (carry crosses all 4 segments).
- a=0x8000, b=0x0001, sub=1:
  - Without SAT_EN -> sum=0x7FFF, carry_out=1, overflow=1.
  - With SAT_EN -> sum=0x8000, overflow=1.
- a=0x7FFF, b=0x0001 -> overflow=1; sum=0x8000 without SAT_EN, 0x7FFF with it.
- 6 back-to-back ops (a=i, b=i, i=1..6); drop out_ready for 3 cycles after the first result:
  - in_ready=0 during the stall; sum held at 0x0002.
  - Results emerge 0x0002..0x000C in order, none lost.
- 3 ops in flight; assert rst for 1 cycle -> out_valid=0 and sum=0 immediately; no stale result appears afterward; a new op after release returns correctly 4 cycles later.
